// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module      : display_scan
// Description : Captures the calculator (data, pos) digit stream into an
//               N_DIGITS digit store and time-multiplexes it onto a
//               common-anode 7-segment display. Status error blinks the
//               whole display; status busy lights the dp of digit 0.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          data,
    input  logic [3:0]          pos,
    input  logic [1:0]          status,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          seg
);

    // Counter/index widths: $clog2 of the divisor, never narrower than 1 bit
    localparam int IDX_W = (N_DIGITS    > 1) ? $clog2(N_DIGITS)    : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [1:0] STATUS_ERROR = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;

    // Digit store and scan/blink state
    logic [3:0]          r_store [N_DIGITS];
    logic [IDX_W-1:0]    r_idx;
    logic [REF_W-1:0]    r_ref_cnt;
    logic [BLK_W-1:0]    r_blk_cnt;
    logic                r_phase;

    // Combinational view of the digit currently being scanned
    logic [3:0]          w_code;
    logic [N_DIGITS-1:0] w_blank;
    logic                w_dp;
    logic [N_DIGITS-1:0] w_an_scan;
    logic                w_error;

    assign w_error = (status == STATUS_ERROR);

    // 7-segment glyph table, gfedcba, 0 = lit
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0111111;   // '-'
            4'hB:    g = 7'b0000011;   // 'b'
            4'hC:    g = 7'b0001000;   // 'A'
            4'hD:    g = 7'b0100001;   // 'd'
            4'hE:    g = 7'b0000110;   // 'E'
            default: g = 7'b1111111;   // blank
        endcase
        return g;
    endfunction

    // Digit store: any in-range pos writes every cycle, last value wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_store[i] <= CODE_BLANK;
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if ({28'd0, pos} == 32'(i)) begin
                    r_store[i] <= data;
                end
            end
        end
    end

    // Refresh divider and scan index; index advances on each divider wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else if (r_ref_cnt == REF_LAST) begin
            r_ref_cnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
        end
    end

    // Blink divider: runs only while in error, phase toggles on every wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (!w_error) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_blk_cnt == BLK_LAST) begin
            r_blk_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_blk_cnt <= r_blk_cnt + BLK_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above 0 is blanked when it and every higher digit hold 0 or F
    always_comb begin
        logic run;
        w_blank = '0;
        run     = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run = run & ((r_store[i] == 4'h0) || (r_store[i] == CODE_BLANK));
            if (i > 0) begin
                w_blank[i] = run;
            end
        end
    end
`else
    // Every digit is drawn exactly as stored
    always_comb begin
        w_blank = '0;
    end
`endif

    // Select the scanned digit, applying the blanking mask
    always_comb begin
        w_code = CODE_BLANK;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code = w_blank[i] ? CODE_BLANK : r_store[i];
            end
        end
    end

    // Busy indicator on digit 0's decimal point; scan enable is one-hot-low
    always_comb begin
        w_dp      = ~((status == STATUS_BUSY) && (r_idx == '0));
        w_an_scan = ~(N_DIGITS'(1) << r_idx);
    end

    // Registered display drive; blink phase 1 blanks all digit enables
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= 8'hFF;
        end else begin
            an  <= r_phase ? '1 : w_an_scan;
            seg <= {w_dp, decode(w_code)};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan
// Description : Directed self-checking bench for display_scan with
//               N_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16. Honours the
//               LEADING_ZERO_BLANK_EN macro when choosing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data  = 4'h0;
    logic [3:0] pos   = 4'hF;
    logic [1:0] status = 2'b11;
    logic [3:0] an;
    logic [7:0] seg;

    int compared   = 0;
    int mismatched = 0;
    int ecount;

    display_scan #(
        .N_DIGITS   (4),
        .REFRESH_DIV(4),
        .BLINK_DIV  (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .data  (data),
        .pos   (pos),
        .status(status),
        .an    (an),
        .seg   (seg)
    );

    always #5 clock = ~clock;

    // Edges since reset release; the value registered at edge e reflects
    // scan index ((e-1)/4)%4
    always @(posedge clock or posedge reset) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    function automatic int exp_idx();
        return ((ecount - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] scan_an(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        status = 2'b11;
        pos    = 4'hF;
        data   = 4'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        compared++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_first an=%b seg=%h expected an=1111 seg=ff", an, seg);
        end
        for (int k = 1; k < 20; k++) begin
            @(posedge clock); #1;
            compared++;
            if (an !== scan_an(exp_idx()) || seg !== 8'hFF) begin
                mismatched++;
                $display("FAIL reset_scan k=%0d an=%b seg=%h expected an=%b seg=ff",
                         k, an, seg, scan_an(exp_idx()));
            end
        end
    endtask

    task automatic test_write();
        logic [7:0] e;
        @(negedge clock); pos = 4'd0; data = 4'd7;
        @(negedge clock); pos = 4'd1; data = 4'd3;
        @(negedge clock); pos = 4'hF; data = 4'd0;
        repeat (2) @(posedge clock);
        for (int k = 0; k < 16; k++) begin
            @(posedge clock); #1;
            e = (exp_idx() == 0) ? 8'hF8 : (exp_idx() == 1) ? 8'hB0 : 8'hFF;
            compared++;
            if (seg !== e || an !== scan_an(exp_idx())) begin
                mismatched++;
                $display("FAIL write idx=%0d seg=%h an=%b expected seg=%h an=%b",
                         exp_idx(), seg, an, e, scan_an(exp_idx()));
            end
        end
    endtask

    task automatic test_ignored_pos();
        logic [7:0] e;
        @(negedge clock); pos = 4'd5; data = 4'd1;
        @(negedge clock); pos = 4'd4; data = 4'd1;
        @(negedge clock); pos = 4'hF; data = 4'd0;
        repeat (2) @(posedge clock);
        for (int k = 0; k < 16; k++) begin
            @(posedge clock); #1;
            e = (exp_idx() == 0) ? 8'hF8 : (exp_idx() == 1) ? 8'hB0 : 8'hFF;
            compared++;
            if (seg !== e) begin
                mismatched++;
                $display("FAIL ignored_pos idx=%0d seg=%h expected %h", exp_idx(), seg, e);
            end
        end
    endtask

    task automatic test_busy_dp();
        logic [7:0] e;
        @(negedge clock); pos = 4'd0; data = 4'd0; status = 2'b01;
        @(negedge clock); pos = 4'hF;
        repeat (2) @(posedge clock);
        for (int k = 0; k < 16; k++) begin
            @(posedge clock); #1;
            e = (exp_idx() == 0) ? 8'h40 : (exp_idx() == 1) ? 8'hB0 : 8'hFF;
            compared++;
            if (seg !== e) begin
                mismatched++;
                $display("FAIL busy_dp idx=%0d seg=%h expected %h", exp_idx(), seg, e);
            end
        end
        @(negedge clock); status = 2'b11;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_blink();
        logic [3:0] e;
        @(negedge clock); status = 2'b00;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            e = (k >= 16 && k <= 31) ? 4'hF : scan_an(exp_idx());
            compared++;
            if (an !== e) begin
                mismatched++;
                $display("FAIL blink k=%0d an=%b expected %b", k, an, e);
            end
        end
        @(negedge clock); status = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            compared++;
            if (an !== scan_an(exp_idx())) begin
                mismatched++;
                $display("FAIL blink_exit k=%0d an=%b expected %b", k, an, scan_an(exp_idx()));
            end
        end
        // Re-entry must start from a cleared blink counter
        @(negedge clock); status = 2'b00;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            e = (k >= 16) ? 4'hF : scan_an(exp_idx());
            compared++;
            if (an !== e) begin
                mismatched++;
                $display("FAIL blink_reentry k=%0d an=%b expected %b", k, an, e);
            end
        end
        @(negedge clock); status = 2'b11;
        repeat (2) @(posedge clock);
        @(posedge clock); #1;
        compared++;
        if (an !== scan_an(exp_idx())) begin
            mismatched++;
            $display("FAIL blink_off an=%b expected %b", an, scan_an(exp_idx()));
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] e [4];
        logic [3:0] top;
        for (int c = 0; c < 3; c++) begin
            top = (c == 0) ? 4'h0 : (c == 1) ? 4'hF : 4'h1;
            @(negedge clock); pos = 4'd3; data = top;
            @(negedge clock); pos = 4'd2; data = 4'h0;
            @(negedge clock); pos = 4'd1; data = 4'h4;
            @(negedge clock); pos = 4'd0; data = 4'h0;
            @(negedge clock); pos = 4'hF;
            e[0] = 8'hC0;
            e[1] = 8'h99;
            if (c == 2) begin
                e[3] = 8'hF9;
                e[2] = 8'hC0;
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                e[3] = 8'hFF;
                e[2] = 8'hFF;
`else
                e[3] = (c == 1) ? 8'hFF : 8'hC0;
                e[2] = 8'hC0;
`endif
            end
            repeat (2) @(posedge clock);
            for (int k = 0; k < 16; k++) begin
                @(posedge clock); #1;
                compared++;
                if (seg !== e[exp_idx()]) begin
                    mismatched++;
                    $display("FAIL leading_zero case=%0d idx=%0d seg=%h expected %h",
                             c, exp_idx(), seg, e[exp_idx()]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        compared++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_async an=%b seg=%h expected an=1111 seg=ff", an, seg);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            compared++;
            if (an !== scan_an(exp_idx()) || seg !== 8'hFF) begin
                mismatched++;
                $display("FAIL reset_mid k=%0d an=%b seg=%h expected an=%b seg=ff",
                         k, an, seg, scan_an(exp_idx()));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_ignored_pos();
        test_busy_dp();
        test_blink();
        test_leading_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
